fetch_pc_gen: RTL and testbench

//  Owns the fetch PC, one stage upstream of branch prediction and the I-cache. Each cycle fetch_pc

---
 rtl/fetch_pc_gen.sv | 153 +++++++++++++++
 tb/tb_fetch_pc_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the fetch PC, issues 16-byte I-cache block requests under a credit
// limit, tracks in-flight requests in order, and buffers returned blocks in a fetch queue.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic [31:0]  pred_next_pc,
  output logic [31:0]  fetch_pc,
  output logic         icache_req_valid,
  input  logic         icache_req_ready,
  output logic [31:0]  icache_req_addr,
  input  logic         icache_resp_valid,
  input  logic [127:0] icache_resp_data,
  output logic         fq_valid,
  input  logic         fq_ready,
  output logic [31:0]  fq_pc,
  output logic [1:0]   fq_start,
  output logic [127:0] fq_data
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] OCC_LIMIT = FQ_DEPTH[CNT_W:0];

  typedef struct packed {
    logic [31:0]  pc;
    logic [127:0] data;
  } fq_entry_t;

  // In-flight tag queue: request PC plus a live bit cleared by redirect.
  logic [31:0]          tag_pc_mem [FQ_DEPTH];
  logic [FQ_DEPTH-1:0]  tag_live;
  logic [PTR_W-1:0]     tag_wr_ptr;
  logic [PTR_W-1:0]     tag_rd_ptr;
  logic [CNT_W-1:0]     tag_cnt;

  fq_entry_t            fq_mem [FQ_DEPTH];
  logic [PTR_W-1:0]     fq_wr_ptr;
  logic [PTR_W-1:0]     fq_rd_ptr;
  logic [CNT_W-1:0]     fq_cnt;

  logic [CNT_W:0]       occ;
  logic                 req_fire;
  logic                 resp_pop;
  logic                 fq_push;
  logic                 fq_pop;
  logic [31:0]          next_pc;

  // Credit covers both in-flight requests and queued blocks, so every response finds a free slot.
  assign occ              = {1'b0, tag_cnt} + {1'b0, fq_cnt};
  assign icache_req_valid = resetn & (occ < OCC_LIMIT) & ~redirect_valid;
  assign icache_req_addr  = {fetch_pc[31:4], 4'b0000};
  assign req_fire         = icache_req_valid & icache_req_ready;

  assign resp_pop = icache_resp_valid & (tag_cnt != '0);
  assign fq_push  = resp_pop & tag_live[tag_rd_ptr] & ~redirect_valid;
  assign fq_pop   = fq_valid & fq_ready & ~redirect_valid;

  assign fq_valid = (fq_cnt != '0);
  assign fq_pc    = fq_mem[fq_rd_ptr].pc;
  assign fq_start = fq_mem[fq_rd_ptr].pc[3:2];
  assign fq_data  = fq_mem[fq_rd_ptr].data;

  // A sequential prediction is realigned to the next block so a mid-block start advances cleanly.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    next_pc = pred_next_pc;
    if (pred_next_pc == fetch_pc + 32'd16) begin
      next_pc = {fetch_pc[31:4] + 28'd1, 4'b0000};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (req_fire) begin
      fetch_pc <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
      tag_live   <= '0;
    end else begin
      if (req_fire) begin
        tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
      end
      if (resp_pop) begin
        tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
      end
      case ({req_fire, resp_pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
      // Killed entries keep their slot (and credit) until the matching response drains them.
      if (redirect_valid) begin
        tag_live <= '0;
      end else if (req_fire) begin
        tag_live[tag_wr_ptr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fq_wr_ptr <= '0;
      fq_rd_ptr <= '0;
      fq_cnt    <= '0;
    end else if (redirect_valid) begin
      fq_wr_ptr <= '0;
      fq_rd_ptr <= '0;
      fq_cnt    <= '0;
    end else begin
      if (fq_push) begin
        fq_wr_ptr <= fq_wr_ptr + PTR_W'(1);
      end
      if (fq_pop) begin
        fq_rd_ptr <= fq_rd_ptr + PTR_W'(1);
      end
      case ({fq_push, fq_pop})
        2'b10:   fq_cnt <= fq_cnt + CNT_W'(1);
        2'b01:   fq_cnt <= fq_cnt - CNT_W'(1);
        default: fq_cnt <= fq_cnt;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; occupancy counters and live bits alone define validity.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_pc_mem[tag_wr_ptr] <= fetch_pc;
    end
    if (fq_push) begin
      fq_mem[fq_wr_ptr] <= '{pc: tag_pc_mem[tag_rd_ptr], data: icache_resp_data};
    end
  end

  // A response with nothing in flight is a protocol error; the design ignores it.
  resp_needs_tag: assert property (@(posedge clk) disable iff (!resetn)
    icache_resp_valid |-> (tag_cnt != '0));

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: drives the I-cache and decode sides by hand, one cycle at a time,
// and compares outputs against hand-computed values.
module tb_fetch_pc_gen;

  logic         clk = 1'b0;
  logic         resetn;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic [31:0]  pred_next_pc;
  logic [31:0]  fetch_pc;
  logic         icache_req_valid;
  logic         icache_req_ready;
  logic [31:0]  icache_req_addr;
  logic         icache_resp_valid;
  logic [127:0] icache_resp_data;
  logic         fq_valid;
  logic         fq_ready;
  logic [31:0]  fq_pc;
  logic [1:0]   fq_start;
  logic [127:0] fq_data;

  logic         pred_taken;
  logic [31:0]  pred_target;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [127:0] D0 = 128'h0000_0003_0000_0002_0000_0001_0000_0000;
  localparam logic [127:0] D1 = 128'h0000_0013_0000_0012_0000_0011_0000_0010;
  localparam logic [127:0] D2 = 128'h0000_0023_0000_0022_0000_0021_0000_0020;
  localparam logic [127:0] EX = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
  localparam logic [127:0] F2 = 128'h1000_100C_1000_1008_1000_1004_1000_1000;
  localparam logic [127:0] G0 = 128'h0000_000C_0000_0008_0000_0004_0000_0000;
  localparam logic [127:0] G1 = 128'h0000_001C_0000_0018_0000_0014_0000_0010;

  // Predictor stand-in: sequential unless a taken target is being forced.
  assign pred_next_pc = pred_taken ? pred_target : fetch_pc + 32'd16;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk               (clk),
    .resetn            (resetn),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .pred_next_pc      (pred_next_pc),
    .fetch_pc          (fetch_pc),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_req_addr   (icache_req_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .fq_valid          (fq_valid),
    .fq_ready          (fq_ready),
    .fq_pc             (fq_pc),
    .fq_start          (fq_start),
    .fq_data           (fq_data)
  );

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Apply one cycle's inputs, then let combinational outputs settle before checking.
  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic respv, input logic [127:0] rdata, input logic fqr);
    redirect_valid    = rv;
    redirect_pc       = rpc;
    icache_req_ready  = rdy;
    icache_resp_valid = respv;
    icache_resp_data  = rdata;
    fq_ready          = fqr;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn      = 1'b1;
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    drive(0, 32'h0, 0, 0, '0, 0);
    resetn = 1'b0;
    #1;
    check("reset_fetch_pc", fetch_pc, 32'h8000_0000);
    check("reset_req_valid", icache_req_valid, 1'b0);
    check("reset_fq_valid", fq_valid, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Sequential fetch with a one-cycle I-cache, then drain the queue in order.
    drive(0, 32'h0, 1, 0, '0, 0);
    check("seq_req_valid", icache_req_valid, 1'b1);
    check("seq_addr0", icache_req_addr, 32'h8000_0000);
    next_cycle();
    drive(0, 32'h0, 1, 1, D0, 0);
    check("seq_addr1", icache_req_addr, 32'h8000_0010);
    check("seq_fq_empty", fq_valid, 1'b0);
    next_cycle();
    drive(0, 32'h0, 1, 1, D1, 0);
    check("seq_addr2", icache_req_addr, 32'h8000_0020);
    check("seq_fq_latency", fq_valid, 1'b1);
    next_cycle();
    drive(0, 32'h0, 0, 1, D2, 0);
    next_cycle();
    drive(0, 32'h0, 0, 0, '0, 1);
    check("pop0_pc", fq_pc, 32'h8000_0000);
    check("pop0_start", fq_start, 2'b00);
    check("pop0_data", fq_data, D0);
    next_cycle();
    drive(0, 32'h0, 0, 0, '0, 1);
    check("pop1_pc", fq_pc, 32'h8000_0010);
    check("pop1_data", fq_data, D1);
    next_cycle();
    drive(0, 32'h0, 0, 0, '0, 1);
    check("pop2_pc", fq_pc, 32'h8000_0020);
    check("pop2_data", fq_data, D2);
    next_cycle();

    // Credit limit: decode stalled, four blocks fill the queue.
    drive(0, 32'h0, 1, 0, '0, 0);
    check("drained_fq_valid", fq_valid, 1'b0);
    check("credit_addr0", icache_req_addr, 32'h8000_0030);
    next_cycle();
    drive(0, 32'h0, 1, 1, EX, 0);
    next_cycle();
    drive(0, 32'h0, 1, 1, EX, 0);
    next_cycle();
    drive(0, 32'h0, 1, 1, EX, 0);
    next_cycle();
    drive(0, 32'h0, 1, 1, EX, 0);
    check("credit_full_a", icache_req_valid, 1'b0);
    next_cycle();
    drive(0, 32'h0, 1, 0, '0, 1);
    check("credit_full_b", icache_req_valid, 1'b0);
    check("credit_head", fq_pc, 32'h8000_0030);
    next_cycle();
    drive(0, 32'h0, 1, 0, '0, 0);
    check("credit_one_free", icache_req_valid, 1'b1);
    check("credit_one_addr", icache_req_addr, 32'h8000_0070);
    next_cycle();
    drive(0, 32'h0, 1, 1, EX, 0);
    check("credit_exactly_one", icache_req_valid, 1'b0);
    next_cycle();
    drive(0, 32'h0, 1, 0, '0, 1);
    check("credit_full_c", icache_req_valid, 1'b0);
    check("credit_head2", fq_pc, 32'h8000_0040);
    next_cycle();
    drive(0, 32'h0, 1, 0, '0, 0);
    check("pre_redirect_addr", icache_req_addr, 32'h8000_0080);
    next_cycle();

    // Redirect colliding with a response and a pop while the queue holds three blocks.
    drive(1, 32'h8000_0100, 1, 1, EX, 1);
    check("redir_no_req", icache_req_valid, 1'b0);
    next_cycle();
    drive(0, 32'h0, 1, 0, '0, 0);
    check("redir_flush", fq_valid, 1'b0);
    check("redir_fetch_pc", fetch_pc, 32'h8000_0100);
    check("redir_credit_back", icache_req_valid, 1'b1);
    next_cycle();

    // Two requests in flight, then redirect to a mid-block target.
    drive(0, 32'h0, 1, 0, '0, 0);
    check("kill_addr1", icache_req_addr, 32'h8000_0110);
    next_cycle();
    drive(1, 32'h8000_1004, 1, 0, '0, 0);
    check("kill_no_req", icache_req_valid, 1'b0);
    next_cycle();
    drive(0, 32'h0, 1, 1, EX, 0);
    check("kill_req_valid", icache_req_valid, 1'b1);
    check("kill_req_addr", icache_req_addr, 32'h8000_1000);
    next_cycle();
    drive(0, 32'h0, 0, 1, EX, 0);
    check("kill_discard_a", fq_valid, 1'b0);
    check("midblock_seq_pc", fetch_pc, 32'h8000_1010);
    next_cycle();
    drive(0, 32'h0, 0, 1, F2, 0);
    check("kill_discard_b", fq_valid, 1'b0);
    next_cycle();
    drive(0, 32'h0, 0, 0, '0, 1);
    check("kill_live_valid", fq_valid, 1'b1);
    check("kill_live_pc", fq_pc, 32'h8000_1004);
    check("kill_live_start", fq_start, 2'b01);
    check("kill_live_data", fq_data, F2);
    next_cycle();

    // Next-PC selection: sequential realignment, then a taken branch, then hold without ready.
    drive(1, 32'h8000_0008, 0, 0, '0, 0);
    next_cycle();
    pred_taken  = 1'b1;
    pred_target = 32'h8000_0018;
    drive(0, 32'h0, 1, 0, '0, 0);
    check("np_start_pc", fetch_pc, 32'h8000_0008);
    check("np_start_addr", icache_req_addr, 32'h8000_0000);
    next_cycle();
    pred_target = 32'h8000_0200;
    drive(0, 32'h0, 1, 0, '0, 0);
    check("np_seq_align", fetch_pc, 32'h8000_0010);
    next_cycle();
    pred_taken = 1'b0;
    drive(0, 32'h0, 0, 1, G0, 0);
    check("np_taken", fetch_pc, 32'h8000_0200);
    check("np_taken_addr", icache_req_addr, 32'h8000_0200);
    next_cycle();
    drive(0, 32'h0, 0, 1, G1, 0);
    check("np_hold", fetch_pc, 32'h8000_0200);
    check("np_hold_valid", icache_req_valid, 1'b1);
    next_cycle();
    drive(1, 32'hFFFF_FFF0, 0, 0, '0, 0);
    check("np_fq_pc", fq_pc, 32'h8000_0008);
    check("np_fq_start", fq_start, 2'b10);
    check("np_fq_data", fq_data, G0);
    next_cycle();

    // Address wrap at the top of the space.
    drive(0, 32'h0, 1, 0, '0, 0);
    check("wrap_addr", icache_req_addr, 32'hFFFF_FFF0);
    next_cycle();
    drive(0, 32'h0, 0, 1, EX, 0);
    check("wrap_fetch_pc", fetch_pc, 32'h0000_0000);
    next_cycle();
    drive(0, 32'h0, 0, 0, '0, 0);
    check("wrap_fq_pc", fq_pc, 32'hFFFF_FFF0);

    // Asynchronous reset between edges with the queue occupied.
    #2;
    resetn = 1'b0;
    #1;
    check("areset_fq_valid", fq_valid, 1'b0);
    check("areset_req_valid", icache_req_valid, 1'b0);
    check("areset_fetch_pc", fetch_pc, 32'h8000_0000);
    next_cycle();
    resetn = 1'b1;
    drive(0, 32'h0, 0, 0, '0, 0);
    check("release_fetch_pc", fetch_pc, 32'h8000_0000);
    check("release_req_valid", icache_req_valid, 1'b1);
    check("release_fq_valid", fq_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
